// File: rtl/spike_noc_pkg.sv
// Shared definitions for the spike-packet link: flit field layout, FSM states
// and the synaptic event payload carried from the receiver to the neuron core.
package spike_noc_pkg;

  localparam int unsigned FLIT_W   = 32;
  localparam int unsigned TYPE_LSB = 30;
  localparam int unsigned DEST_LSB = 22;
  localparam int unsigned DEST_W   = 8;
  localparam int unsigned SRC_LSB  = 12;
  localparam int unsigned SRC_W    = 10;
  localparam int unsigned N_LSB    = 4;
  localparam int unsigned N_W      = 8;
  localparam int unsigned TGT_LSB  = 20;
  localparam int unsigned TGT_W    = 10;
  localparam int unsigned WEIGHT_LSB = 0;
  localparam int unsigned WEIGHT_W   = 16;
  localparam int unsigned EV_W     = SRC_W + TGT_W + WEIGHT_W;

  typedef enum logic [1:0] {
    FLIT_NONE = 2'b00,
    FLIT_HEAD = 2'b01,
    FLIT_BODY = 2'b10,
    FLIT_TAIL = 2'b11
  } flit_type_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RECV = 2'd1,
    ST_DROP = 2'd2
  } state_e;

  typedef struct packed {
    logic [SRC_W-1:0]    src;
    logic [TGT_W-1:0]    tgt;
    logic [WEIGHT_W-1:0] weight;
  } spike_event_t;

endpackage

// File: rtl/spike_event_fifo.sv
// Synchronous event FIFO; head entry is driven straight from storage so a push
// is visible on data_o the cycle after it is written.
module spike_event_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 36,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [W-1:0]     data_i,
  output logic [W-1:0]     data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_q, rd_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push, do_pop;

  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= data_i;
        wr_q        <= wr_q + PTR_W'(1);
      end
      if (do_pop) rd_q <= rd_q + PTR_W'(1);
      count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  assign data_o  = mem_q[rd_q];
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

endmodule

// File: rtl/spike_flit_receiver.sv
// Receive end of the spike NoC link: frames packets, filters on destination,
// unpacks payload flits into synaptic events and keeps saturating error counts.
module spike_flit_receiver
  import spike_noc_pkg::*;
#(
  parameter logic [7:0]  NODE_ID    = 8'h05,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned ERR_W      = 8
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic [FLIT_W-1:0]   in_flit,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [SRC_W-1:0]    ev_src,
  output logic [TGT_W-1:0]    ev_tgt,
  output logic [WEIGHT_W-1:0] ev_weight,
  output logic                ev_valid,
  input  logic                ev_ready,
  output logic [ERR_W-1:0]    err_count,
  output logic [ERR_W-1:0]    drop_count
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [ERR_W-1:0] CNT_MAX = '1;

  state_e            state_q, state_d;
  logic [N_W-1:0]    rem_q, rem_d;
  logic [SRC_W-1:0]  src_q, src_d;
  logic [ERR_W-1:0]  err_q, err_d, drop_q, drop_d;
  logic [1:0]        err_inc;
  logic              drop_inc, push, accept;
  flit_type_e        ftype, exp_type;
  logic [DEST_W-1:0] f_dest;
  logic [SRC_W-1:0]  f_src;
  logic [N_W-1:0]    f_n;
  spike_event_t      ev_in, ev_head;
  logic              fifo_full, fifo_empty;
  logic [CNT_W-1:0]  fifo_count;
  logic              unused_ok;

  function automatic logic [ERR_W-1:0] sat_add(input logic [ERR_W-1:0] a,
                                               input logic [1:0] inc);
    logic [ERR_W+1:0] s;
    s = (ERR_W+2)'(a) + (ERR_W+2)'(inc);
    return (s > (ERR_W+2)'(CNT_MAX)) ? CNT_MAX : s[ERR_W-1:0];
  endfunction

  assign accept   = in_valid & in_ready;
  assign ftype    = flit_type_e'(in_flit[TYPE_LSB +: 2]);
  assign f_dest   = in_flit[DEST_LSB +: DEST_W];
  assign f_src    = in_flit[SRC_LSB +: SRC_W];
  assign f_n      = in_flit[N_LSB +: N_W];
  assign exp_type = (rem_q == N_W'(1)) ? FLIT_TAIL : FLIT_BODY;
  assign ev_in    = '{src: src_q, tgt: in_flit[TGT_LSB +: TGT_W],
                      weight: in_flit[WEIGHT_LSB +: WEIGHT_W]};
  assign unused_ok = ^{in_flit[19:16], in_flit[3:0], fifo_count};

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= ST_IDLE;
      rem_q   <= '0;
      src_q   <= '0;
      err_q   <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      src_q   <= src_d;
      err_q   <= err_d;
      drop_q  <= drop_d;
    end
  end

  // A HEAD outside IDLE aborts the packet, then is handled as a fresh HEAD.
  always_comb begin
    state_d  = state_q;
    rem_d    = rem_q;
    src_d    = src_q;
    err_inc  = 2'd0;
    drop_inc = 1'b0;
    push     = 1'b0;
    if (accept) begin
      if (ftype == FLIT_HEAD) begin
        if (state_q != ST_IDLE) err_inc = 2'd1;
        if (f_dest != NODE_ID) begin
          drop_inc = 1'b1;
          rem_d    = f_n;
          state_d  = (f_n != '0) ? ST_DROP : ST_IDLE;
        end else if (f_n == '0) begin
          err_inc = err_inc + 2'd1;
          rem_d   = '0;
          state_d = ST_IDLE;
        end else begin
          src_d   = f_src;
          rem_d   = f_n;
          state_d = ST_RECV;
        end
      end else if (state_q == ST_IDLE) begin
        err_inc = 2'd1;
      end else if (ftype == exp_type) begin
        push  = (state_q == ST_RECV);
        rem_d = rem_q - N_W'(1);
        if (rem_q == N_W'(1)) state_d = ST_IDLE;
      end else begin
        err_inc = 2'd1;
        rem_d   = '0;
        state_d = ST_IDLE;
      end
    end
    err_d  = sat_add(err_q, err_inc);
    drop_d = sat_add(drop_q, {1'b0, drop_inc});
  end

  spike_event_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (EV_W)
  ) u_fifo (
    .clk     (CLK),
    .rst     (RESET),
    .push_i  (push),
    .pop_i   (ev_valid & ev_ready),
    .data_i  (ev_in),
    .data_o  (ev_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign in_ready   = ~fifo_full;
  assign ev_valid   = ~fifo_empty;
  assign ev_src     = ev_head.src;
  assign ev_tgt     = ev_head.tgt;
  assign ev_weight  = ev_head.weight;
  assign err_count  = err_q;
  assign drop_count = drop_q;

endmodule
